// File: rtl/ex_pkg.sv
// Shared definitions for the execute result stage: opcode and FSM state
// encodings, saturation limits, and the register-write predicate.
package ex_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LLB    = 4'b1010,
    OP_LHB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } opcode_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // LW is excluded: its writeback comes from memory, not from this stage.
  function automatic logic writes_reg(opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR,
      OP_PADDSB, OP_LLB, OP_LHB, OP_PCS: writes_reg = 1'b1;
      default:                           writes_reg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_detect.sv
// 16-bit signed overflow detection and saturation.
// Ports:
//   a       - operand A
//   eb      - effective operand B as fed to the adder (~B for subtract)
//   sum     - adder sum
//   ovf     - signed overflow occurred
//   sat_val - sum, or the signed limit matching A's sign on overflow
module sat_detect
  import ex_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] eb,
  input  logic [15:0] sum,
  output logic        ovf,
  output logic [15:0] sat_val
);

  // Only the sign bits of a and eb matter for overflow detection.
  logic unused_low_bits;
  assign unused_low_bits = ^{a[14:0], eb[14:0]};

  assign ovf     = (a[15] == eb[15]) && (sum[15] != a[15]);
  assign sat_val = ovf ? (a[15] ? SAT_NEG : SAT_POS) : sum;

endmodule

// File: rtl/ex_result_stage.sv
// Execute result stage: saturates ADD/SUB adder results, selects the final
// result, maintains Z/V/N flags and registers the beat toward writeback
// behind a valid/ready handshake. A HLT beat stops the stage until reset.
//
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   in_valid/in_ready       - upstream handshake
//   in_op, in_a, in_b       - opcode and ISA operands
//   in_sum                  - adder sum (SUB fed ~B with Cin=1)
//   in_alt                  - shift/RED/PADDSB/LLB/LHB/PCS unit result
//   in_dst                  - destination register index
//   out_valid/out_ready     - downstream handshake
//   out_result, out_dst     - registered result and destination
//   out_wr_en               - register-file write enable for this beat
//   flag_z, flag_v, flag_n  - flag register
//   halted                  - stage has accepted HLT
//   ovf_count               - saturating ADD/SUB overflow count
//                             (present only with EX_OVF_COUNT_EN defined)
//
// State | Meaning
// RUN    | accepting beats
// HALTED | HLT accepted; no further beats until reset, output may drain
module ex_result_stage
  import ex_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_sum,
  input  logic [DW-1:0] in_alt,
  input  logic [RW-1:0] in_dst,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_dst,
  output logic          out_wr_en,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          halted
`ifdef EX_OVF_COUNT_EN
  ,
  output logic [15:0]   ovf_count
`endif
);

  state_t        state, state_nx;
  opcode_t       op;
  logic          accept;
  logic          is_addsub;
  logic          z_only;
  logic          ovf;
  logic [DW-1:0] eb;
  logic [DW-1:0] sat_val;
  logic [DW-1:0] res_d;

  assign op        = opcode_t'(in_op);
  assign is_addsub = (op == OP_ADD) || (op == OP_SUB);
  assign z_only    = (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  assign eb        = (op == OP_SUB) ? ~in_b : in_b;

  sat_detect u_sat (
    .a       (in_a),
    .eb      (eb),
    .sum     (in_sum),
    .ovf     (ovf),
    .sat_val (sat_val)
  );

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign halted   = (state == HALTED);

  always_comb begin
    res_d = '0;
    case (op)
      OP_ADD, OP_SUB:                     res_d = sat_val;
      OP_XOR:                             res_d = in_a ^ in_b;
      OP_RED, OP_SLL, OP_SRA, OP_ROR,
      OP_PADDSB, OP_LLB, OP_LHB, OP_PCS:  res_d = in_alt;
      OP_LW, OP_SW:                       res_d = in_sum;
      default:                            res_d = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (accept && (op == OP_HLT)) state_nx = HALTED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_dst    <= '0;
      out_wr_en  <= 1'b0;
      flag_z     <= 1'b0;
      flag_v     <= 1'b0;
      flag_n     <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= res_d;
      out_dst    <= in_dst;
      out_wr_en  <= writes_reg(op);
      if (is_addsub) begin
        flag_z <= (res_d == '0);
        flag_v <= ovf;
        flag_n <= res_d[DW-1];
      end else if (z_only) begin
        flag_z <= (res_d == '0);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef EX_OVF_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf_count <= '0;
    else if (accept && is_addsub && ovf && (ovf_count != 16'hFFFF))
      ovf_count <= ovf_count + 16'd1;
  end
`endif

endmodule
